// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtraction controller.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/bit_sub_cell.sv
// Gate-level full subtractor: two half-subtract stages joined by an OR on the borrows.
module bit_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_bout;
    logic hs2_bout;

    assign hs1_d    = a ^ b;
    assign hs1_bout = ~a & b;
    assign d        = hs1_d ^ bin;
    assign hs2_bout = ~hs1_d & bin;
    assign bout     = hs1_bout | hs2_bout;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b: one subtract cell stepped over WIDTH cycles, LSB first,
// with a start/busy/done handshake toward the host.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_reg;
    logic [WIDTH-1:0]   a_sr_reg;
    logic [WIDTH-1:0]   b_sr_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               borrow_reg;
    logic               borrow_out_reg;
    logic               cell_d;
    logic               cell_bout;

    bit_sub_cell u_cell (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .bin  (borrow_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            a_sr_reg       <= '0;
            b_sr_reg       <= '0;
            diff_reg       <= '0;
            cnt_reg        <= '0;
            borrow_reg     <= 1'b0;
            borrow_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sr_reg       <= a_in;
                        b_sr_reg       <= b_in;
                        diff_reg       <= '0;
                        cnt_reg        <= '0;
                        borrow_reg     <= 1'b0;
                        borrow_out_reg <= 1'b0;
                        state_reg      <= RUN;
                    end
                end
                RUN: begin
                    // Result enters at the MSB so after WIDTH steps bit 0 lands at diff[0].
                    diff_reg   <= (diff_reg >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                    borrow_reg <= cell_bout;
                    a_sr_reg   <= a_sr_reg >> 1;
                    b_sr_reg   <= b_sr_reg >> 1;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        borrow_out_reg <= cell_bout;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed plus random checks of serial_sub_ctrl at WIDTH=8 and WIDTH=1
// against plain unsigned arithmetic.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a_in       (a8),
        .b_in       (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (borrow8)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .a_in       (a1),
        .b_in       (b1),
        .busy       (busy1),
        .done       (done1),
        .diff       (diff1),
        .borrow_out (borrow1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned subtraction with a ninth bit catching the borrow.
    function automatic logic [8:0] ref_sub8(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [8:0] exp;
        int n;
        exp    = ref_sub8(a, b);
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        chk({tag, "_busy_run"}, 32'(busy8), 32'd1);
        chk({tag, "_diff_run"}, 32'(diff8), 32'd0);
        n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_diff"}, 32'(diff8), 32'(exp[7:0]));
        chk({tag, "_borrow"}, 32'(borrow8), 32'(exp[8]));
        $display("op %s: a=%02h b=%02h diff=%02h borrow=%0d latency=%0d", tag, a, b, diff8, borrow8, n);
        tick();
        chk({tag, "_busy_after"}, 32'(busy8), 32'd0);
        chk({tag, "_done_after"}, 32'(done8), 32'd0);
        chk({tag, "_diff_held"}, 32'(diff8), 32'(exp[7:0]));
    endtask

    initial begin
        int pulses;
        int t_done [2];
        logic [7:0] d_done [2];
        logic       b_done [2];
        logic [1:0] ab;
        logic       exp_d;
        logic       exp_b;

        // Reset state
        #1;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_diff8", 32'(diff8), 32'd0);
        chk("rst_borrow8", 32'(borrow8), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed arithmetic
        run_op(8'h05, 8'h03, "t1");
        run_op(8'h03, 8'h05, "t2a");
        run_op(8'h00, 8'h01, "t2b");
        run_op(8'hFF, 8'hFF, "t2c");

        // Start pulses during RUN are ignored
        a8 = 8'h5A; b8 = 8'h21; start8 = 1'b1;
        tick();
        pulses = 0;
        d_done[0] = '0;
        b_done[0] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            start8 = (i == 3 || i == 6);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            tick();
            if (done8) begin
                pulses++;
                d_done[0] = diff8;
                b_done[0] = borrow8;
            end
        end
        start8 = 1'b0;
        chk("t3_pulses", 32'(pulses), 32'd1);
        chk("t3_diff", 32'(d_done[0]), 32'h39);
        chk("t3_borrow", 32'(b_done[0]), 32'd0);
        chk("t3_idle", 32'(busy8), 32'd0);
        $display("op t3: ignored starts, pulses=%0d diff=%02h", pulses, d_done[0]);

        // Asynchronous reset mid-operation
        a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("t4_busy", 32'(busy8), 32'd0);
        chk("t4_done", 32'(done8), 32'd0);
        chk("t4_diff", 32'(diff8), 32'd0);
        chk("t4_borrow", 32'(borrow8), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) pulses++;
        end
        chk("t4_no_done", 32'(pulses), 32'd0);
        $display("op t4: reset abort, stray done pulses=%0d", pulses);
        run_op(8'hC3, 8'h3C, "t4_fresh");

        // Start held high: back-to-back operations
        a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
        tick();
        a8 = 8'h00; b8 = 8'h00;
        pulses = 0;
        t_done[0] = 0;
        t_done[1] = 0;
        for (int i = 2; i <= 30; i++) begin
            tick();
            if (done8 && pulses < 2) begin
                t_done[pulses] = i;
                d_done[pulses] = diff8;
                b_done[pulses] = borrow8;
                pulses++;
                if (pulses == 2) start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        chk("t5_pulses", 32'(pulses), 32'd2);
        chk("t5_first_at", 32'(t_done[0]), 32'd9);
        chk("t5_interval", 32'(t_done[1] - t_done[0]), 32'd10);
        chk("t5_diff0", 32'(d_done[0]), 32'h7F);
        chk("t5_borrow0", 32'(b_done[0]), 32'd0);
        chk("t5_diff1", 32'(d_done[1]), 32'h00);
        chk("t5_borrow1", 32'(b_done[1]), 32'd0);
        $display("op t5: dones at %0d and %0d, %02h then %02h", t_done[0], t_done[1], d_done[0], d_done[1]);
        tick();

        // Random operands
        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), $sformatf("rnd%0d", i));
        end

        // WIDTH=1 exhaustive
        for (int i = 0; i < 4; i++) begin
            ab     = 2'(i);
            exp_d  = ab[1] ^ ab[0];
            exp_b  = (ab[1] < ab[0]);
            a1     = ab[1];
            b1     = ab[0];
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk($sformatf("w1_%0d_busy", i), 32'(busy1), 32'd1);
            chk($sformatf("w1_%0d_early", i), 32'(done1), 32'd0);
            tick();
            chk($sformatf("w1_%0d_done", i), 32'(done1), 32'd1);
            chk($sformatf("w1_%0d_diff", i), 32'(diff1), 32'(exp_d));
            chk($sformatf("w1_%0d_borrow", i), 32'(borrow1), 32'(exp_b));
            $display("op w1_%0d: a=%0d b=%0d diff=%0d borrow=%0d", i, ab[1], ab[0], diff1, borrow1);
            tick();
            chk($sformatf("w1_%0d_idle", i), 32'(busy1), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
